// File: rtl/td4_pkg.sv
// Shared types and constants for the TD4 program-memory loader.
package td4_pkg;

  localparam int unsigned TD4_ADDR_W = 4;
  localparam int unsigned TD4_DATA_W = 8;
  localparam logic [7:0]  TD4_NOP    = 8'h00;

  typedef enum logic [1:0] {
    StRun,
    StLoadLo,
    StLoadHi,
    StFull
  } loader_state_t;

endpackage

// File: rtl/td4_prog_loader_if.sv
// Loader pin bundle: the programming pins in, load progress back out.
interface td4_prog_loader_if
  import td4_pkg::*;
#(
  parameter int unsigned ADDR_W = TD4_ADDR_W,
  parameter int unsigned DATA_W = TD4_DATA_W
);

  logic                  load_mode;
  logic                  wr_strobe;
  logic [DATA_W/2-1:0]   wr_data;
  logic [ADDR_W-1:0]     load_addr;
  logic                  load_done;

  modport master (
    output load_mode,
    output wr_strobe,
    output wr_data,
    input  load_addr,
    input  load_done
  );

  modport slave (
    input  load_mode,
    input  wr_strobe,
    input  wr_data,
    output load_addr,
    output load_done
  );

endinterface

// File: rtl/td4_sync_edge.sv
// Multi-flop synchroniser for an async pin with registered level and rise/fall pulses.
module td4_sync_edge #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic async_in,
  output logic level,
  output logic rise,
  output logic fall
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   level_q;
  logic                   rise_q;
  logic                   fall_q;

  // level_q is the one-clock delayed copy, so level and the edge pulses change together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q  <= '0;
      level_q <= 1'b0;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
    end else begin
      sync_q  <= {sync_q[SYNC_STAGES-2:0], async_in};
      level_q <= sync_q[SYNC_STAGES-1];
      rise_q  <= sync_q[SYNC_STAGES-1] & ~level_q;
      fall_q  <= ~sync_q[SYNC_STAGES-1] & level_q;
    end
  end

  assign level = level_q;
  assign rise  = rise_q;
  assign fall  = fall_q;

endmodule

// File: rtl/td4_prog_loader.sv
// TD4 program store: nibble-wise loader from pins, instr[pc] read port and core step enable.
// Define TD4_SINGLE_STEP_EN to step the core from wr_strobe instead of the free-running divider.
module td4_prog_loader
  import td4_pkg::*;
#(
  parameter int unsigned ADDR_W      = TD4_ADDR_W,
  parameter int unsigned DATA_W      = TD4_DATA_W,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned RUN_DIV_W   = 20
) (
  input  logic               clk,
  input  logic               rst_n,
  td4_prog_loader_if.slave   bus,
  input  logic [ADDR_W-1:0]  pc,
  output logic [DATA_W-1:0]  instr,
  output logic               cpu_run
);

  localparam int unsigned DEPTH = 2 ** ADDR_W;
  localparam int unsigned NIB_W = DATA_W / 2;

  logic mode_level, mode_rise, mode_fall;
  logic strobe_level, strobe_rise, strobe_fall;

  td4_sync_edge #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync_mode (
    .clk     (clk),
    .rst_n   (rst_n),
    .async_in(bus.load_mode),
    .level   (mode_level),
    .rise    (mode_rise),
    .fall    (mode_fall)
  );

  td4_sync_edge #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync_strobe (
    .clk     (clk),
    .rst_n   (rst_n),
    .async_in(bus.wr_strobe),
    .level   (strobe_level),
    .rise    (strobe_rise),
    .fall    (strobe_fall)
  );

  // Mode is acted on by level; only the strobe rising edge matters.
  logic unused_edges;
  assign unused_edges = ^{mode_rise, mode_fall, strobe_level, strobe_fall};

  loader_state_t     state_q;
  logic [ADDR_W-1:0] load_addr_q;
  logic              load_done_q;
  logic [NIB_W-1:0]  lo_q;
  logic              cpu_run_q;
  logic [DATA_W-1:0] mem_q [DEPTH];
`ifndef TD4_SINGLE_STEP_EN
  logic [RUN_DIV_W-1:0] div_q;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StRun;
      load_addr_q <= '0;
      load_done_q <= 1'b0;
      lo_q        <= '0;
      cpu_run_q   <= 1'b0;
`ifndef TD4_SINGLE_STEP_EN
      div_q       <= '0;
`endif
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      cpu_run_q <= 1'b0;
`ifndef TD4_SINGLE_STEP_EN
      // Held at zero outside RUN so the first step comes a full period after entry.
      if (state_q != StRun) begin
        div_q <= '0;
      end
`endif
      // Mode is checked first in every state: a coincident strobe edge is dropped.
      unique case (state_q)
        StRun: begin
          if (mode_level) begin
            state_q     <= StLoadLo;
            load_addr_q <= '0;
            load_done_q <= 1'b0;
          end else begin
`ifdef TD4_SINGLE_STEP_EN
            cpu_run_q <= strobe_rise;
`else
            div_q     <= div_q + 1'b1;
            cpu_run_q <= (div_q == '1);
`endif
          end
        end
        StLoadLo: begin
          if (!mode_level) begin
            state_q <= StRun;
          end else if (strobe_rise) begin
            lo_q    <= bus.wr_data;
            state_q <= StLoadHi;
          end
        end
        StLoadHi: begin
          if (!mode_level) begin
            state_q <= StRun;
          end else if (strobe_rise) begin
            mem_q[load_addr_q] <= {bus.wr_data, lo_q};
            load_addr_q        <= load_addr_q + 1'b1;
            if (load_addr_q == '1) begin
              state_q     <= StFull;
              load_done_q <= 1'b1;
            end else begin
              state_q <= StLoadLo;
            end
          end
        end
        StFull: begin
          if (!mode_level) begin
            state_q <= StRun;
          end
        end
        default: state_q <= StRun;
      endcase
    end
  end

  assign instr         = (state_q == StRun) ? mem_q[pc] : DATA_W'(TD4_NOP);
  assign cpu_run       = cpu_run_q;
  assign bus.load_addr = load_addr_q;
  assign bus.load_done = load_done_q;

endmodule

// File: tb/tb_td4_prog_loader.sv
// Directed bench for td4_prog_loader: vector table for load/readback plus hand sequences.
module tb_td4_prog_loader;

  logic       clk;
  logic       rst_n;
  logic [3:0] pc;
  logic [7:0] instr;
  logic       cpu_run;

  int n_checks = 0;
  int n_errors = 0;

  td4_prog_loader_if #(.ADDR_W(4), .DATA_W(8)) bus ();

  td4_prog_loader #(
    .ADDR_W     (4),
    .DATA_W     (8),
    .SYNC_STAGES(2),
    .RUN_DIV_W  (3)
  ) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .bus    (bus),
    .pc     (pc),
    .instr  (instr),
    .cpu_run(cpu_run)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] lo;
    logic [3:0] hi;
    logic [7:0] exp;
  } vec_t;

  vec_t vecs [6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic set_mode(input logic v);
    bus.load_mode = v;
    wait_cycles(6);
  endtask

  task automatic strobe(input logic [3:0] nib);
    bus.wr_data   = nib;
    bus.wr_strobe = 1'b1;
    wait_cycles(6);
    bus.wr_strobe = 1'b0;
    wait_cycles(6);
  endtask

  task automatic read_word(input string name, input logic [3:0] addr, input logic [7:0] exp);
    pc = addr;
    #1;
    check(name, instr, exp);
  endtask

  initial begin
    vecs[0] = '{lo: 4'h3, hi: 4'hB, exp: 8'hB3};
    vecs[1] = '{lo: 4'h0, hi: 4'h7, exp: 8'h70};
    vecs[2] = '{lo: 4'hF, hi: 4'hF, exp: 8'hFF};
    vecs[3] = '{lo: 4'hA, hi: 4'h5, exp: 8'h5A};
    vecs[4] = '{lo: 4'h1, hi: 4'h2, exp: 8'h21};
    vecs[5] = '{lo: 4'hC, hi: 4'h0, exp: 8'h0C};

    rst_n         = 1'b0;
    bus.load_mode = 1'b0;
    bus.wr_strobe = 1'b0;
    bus.wr_data   = 4'h0;
    pc            = 4'h0;

    // Reset values before any clock edge.
    #1;
    check("rst_instr", instr, 8'h00);
    check("rst_cpu_run", cpu_run, 1'b0);
    check("rst_load_addr", bus.load_addr, 4'h0);
    check("rst_load_done", bus.load_done, 1'b0);

    wait_cycles(3);
    rst_n = 1'b1;

`ifndef TD4_SINGLE_STEP_EN
    for (int k = 1; k <= 24; k++) begin
      @(negedge clk);
      check("step_rate_reset", cpu_run, (k % 8) == 0);
    end
`else
    begin
      int pulses = 0;
      for (int k = 1; k <= 24; k++) begin
        @(negedge clk);
        pulses += int'(cpu_run);
      end
      check("no_free_run", pulses, 0);
    end
`endif

    // Load six words from the table, then read them back in RUN.
    set_mode(1'b1);
    check("load_entry_addr", bus.load_addr, 4'h0);
    check("load_entry_done", bus.load_done, 1'b0);
    for (int i = 0; i < 6; i++) begin
      strobe(vecs[i].lo);
      strobe(vecs[i].hi);
      if (i == 1) check("load_addr_after2", bus.load_addr, 4'h2);
    end
    check("load_addr_after6", bus.load_addr, 4'h6);
    read_word("instr_nop_in_load", 4'h0, 8'h00);
    set_mode(1'b0);
    for (int i = 0; i < 6; i++) begin
      logic [3:0] a;
      a = 4'(i);
      read_word("table_readback", a, vecs[i].exp);
    end

    // Fill all 16 words, then strobe past the end.
    set_mode(1'b1);
    check("reload_addr", bus.load_addr, 4'h0);
    for (int i = 0; i < 16; i++) begin
      logic [3:0] n;
      n = 4'(i);
      strobe(n);
      if (i == 15) begin
        check("pre_full_done", bus.load_done, 1'b0);
        check("pre_full_addr", bus.load_addr, 4'hF);
      end
      strobe(~n);
    end
    check("full_done", bus.load_done, 1'b1);
    check("full_addr", bus.load_addr, 4'h0);
    strobe(4'h9);
    strobe(4'h9);
    check("full_ignore_addr", bus.load_addr, 4'h0);
    check("full_ignore_done", bus.load_done, 1'b1);
    set_mode(1'b0);
    check("done_held_run", bus.load_done, 1'b1);
    read_word("full_mem0", 4'h0, 8'hF0);
    read_word("full_mem7", 4'h7, 8'h87);
    read_word("full_mem15", 4'hF, 8'h0F);

    // Abort after a lone low nibble at address 4.
    set_mode(1'b1);
    check("abort_entry_done", bus.load_done, 1'b0);
    for (int i = 0; i < 4; i++) begin
      logic [3:0] n;
      n = 4'(i);
      strobe(n);
      strobe(4'hA);
    end
    strobe(4'h5);
    check("abort_addr", bus.load_addr, 4'h4);
    bus.load_mode = 1'b0;
`ifndef TD4_SINGLE_STEP_EN
    // Mode fall takes 3 clks to reach the FSM; first step 8 clks after RUN entry.
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      check("step_rate_entry", cpu_run, (k == 12) || (k == 20));
    end
`else
    wait_cycles(20);
`endif
    check("abort_done", bus.load_done, 1'b0);
    read_word("abort_mem3", 4'h3, 8'hA3);
    read_word("abort_mem4", 4'h4, 8'hB4);
    read_word("abort_mem5", 4'h5, 8'hA5);

    // Strobe edge coincident with mode fall: dropped.
    set_mode(1'b1);
    strobe(4'h6);
    bus.wr_data   = 4'hC;
    bus.wr_strobe = 1'b1;
    bus.load_mode = 1'b0;
    wait_cycles(6);
    bus.wr_strobe = 1'b0;
    wait_cycles(6);
    check("collide_addr", bus.load_addr, 4'h0);
    read_word("collide_mem0", 4'h0, 8'hA0);

    // Strobe edge one clk ahead of mode fall: written.
    set_mode(1'b1);
    strobe(4'h6);
    bus.wr_data   = 4'hC;
    bus.wr_strobe = 1'b1;
    wait_cycles(1);
    bus.load_mode = 1'b0;
    wait_cycles(6);
    bus.wr_strobe = 1'b0;
    wait_cycles(6);
    check("early_addr", bus.load_addr, 4'h1);
    read_word("early_mem0", 4'h0, 8'hC6);

`ifdef TD4_SINGLE_STEP_EN
    begin
      int pulses = 0;
      for (int j = 0; j < 3; j++) begin
        bus.wr_strobe = 1'b1;
        for (int c = 0; c < 6; c++) begin
          @(negedge clk);
          pulses += int'(cpu_run);
        end
        bus.wr_strobe = 1'b0;
        for (int c = 0; c < 6; c++) begin
          @(negedge clk);
          pulses += int'(cpu_run);
        end
      end
      check("single_step_pulses", pulses, 3);
    end
`else
    begin
      logic found;
      found = 1'b0;
      for (int j = 0; j < 20 && !found; j++) begin
        @(negedge clk);
        if (cpu_run) found = 1'b1;
      end
      check("pulse_before_reset", found, 1'b1);
    end
`endif

    // Asynchronous reset mid-operation, observed without a clock edge.
    pc = 4'h0;
    #2;
    rst_n = 1'b0;
    #1;
    check("midrst_instr", instr, 8'h00);
    check("midrst_cpu_run", cpu_run, 1'b0);
    check("midrst_load_addr", bus.load_addr, 4'h0);
    check("midrst_load_done", bus.load_done, 1'b0);
    wait_cycles(2);
    rst_n = 1'b1;
    wait_cycles(2);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
